// File: rtl/ctd_timer_core.sv
// ctd_timer_core: BCD mm:ss countdown engine with tick prescaler,
// one-shot / auto-reload modes, completed-cycle counter and low-time warning.
// Handshake: load and cnt_en are plain levels sampled every clock; load wins
// over a tick in the same cycle, and time_out is a one-cycle registered pulse.
module ctd_timer_core #(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned WARN_SEC = 10,
   parameter int unsigned CYC_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             cnt_en,
   input  logic             auto_mode,
   input  logic [7:0]       min_init,
   output logic [7:0]       xmin,
   output logic [7:0]       xsec,
   output logic             time_out,
   output logic             done,
   output logic             warn,
   output logic [CYC_W-1:0] cycle_cnt
);

   localparam int unsigned     PRE_W   = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, RELOAD, DONE} state_t;

   state_t            state, state_nxt;
   logic [PRE_W-1:0]  prescaler, pre_nxt;
   logic [7:0]        min_latch, latch_nxt;
   logic [7:0]        xmin_nxt, xsec_nxt;
   logic              to_nxt, warn_nxt;
   logic [CYC_W-1:0]  cyc_nxt;
   logic              pre_run, tick, zero_hit;
   logic [7:0]        clamped;
   logic [15:0]       dec_val;

   // Clamp each BCD nibble above 9 down to 9.
   function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
      logic [3:0] t, u;
      t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
      u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
      clamp_bcd = {t, u};
   endfunction

   // One-second BCD decrement of mm:ss with borrows; 00:00 stays put.
   function automatic logic [15:0] dec_mmss(input logic [7:0] m, input logic [7:0] s);
      logic [7:0] nm, ns;
      nm = m;
      ns = s;
      if (s[3:0] != 4'd0) begin
         ns[3:0] = s[3:0] - 4'd1;
      end else if (s[7:4] != 4'd0) begin
         ns[7:4] = s[7:4] - 4'd1;
         ns[3:0] = 4'd9;
      end else if (m != 8'h00) begin
         ns = 8'h59;
         if (m[3:0] != 4'd0) begin
            nm[3:0] = m[3:0] - 4'd1;
         end else begin
            nm[7:4] = m[7:4] - 4'd1;
            nm[3:0] = 4'd9;
         end
      end
      dec_mmss = {nm, ns};
   endfunction

   // Low-time test on the binary total of a BCD mm:ss value.
   function automatic logic low_time(input logic [7:0] m, input logic [7:0] s);
      logic [6:0]  mb, sb;
      logic [12:0] total;
      mb    = 7'(m[7:4]) * 7'd10 + 7'(m[3:0]);
      sb    = 7'(s[7:4]) * 7'd10 + 7'(s[3:0]);
      total = 13'(mb) * 13'd60 + 13'(sb);
      low_time = (total != 13'd0) && (32'(total) <= WARN_SEC);
   endfunction

   assign done    = (state == IDLE) || (state == DONE);
   assign pre_run = cnt_en && !done && !load;
   assign tick    = pre_run && (prescaler == PRE_MAX);
   assign clamped = clamp_bcd(min_init);
   assign dec_val = dec_mmss(xmin, xsec);

   // Next-state and datapath decisions: load, then tick, otherwise hold.
   always_comb begin
      state_nxt = state;
      pre_nxt   = prescaler;
      latch_nxt = min_latch;
      xmin_nxt  = xmin;
      xsec_nxt  = xsec;
      to_nxt    = 1'b0;
      cyc_nxt   = cycle_cnt;
      zero_hit  = 1'b0;
      if (pre_run) begin
         pre_nxt = tick ? '0 : prescaler + PRE_W'(1);
      end
      if (load) begin
         pre_nxt   = '0;
         latch_nxt = clamped;
         xmin_nxt  = clamped;
         xsec_nxt  = 8'h00;
         cyc_nxt   = '0;
         state_nxt = (clamped == 8'h00) ? IDLE : RUN;
      end else if (tick) begin
         case (state)
            RUN: begin
               xmin_nxt = dec_val[15:8];
               xsec_nxt = dec_val[7:0];
               zero_hit = (dec_val == 16'h0000);
            end
            RELOAD: begin
               xmin_nxt  = min_latch;
               xsec_nxt  = 8'h00;
               state_nxt = RUN;
               zero_hit  = (min_latch == 8'h00);
            end
            default: ;
         endcase
         if (zero_hit) begin
            to_nxt    = 1'b1;
            cyc_nxt   = cycle_cnt + CYC_W'(1);
            state_nxt = auto_mode ? RELOAD : DONE;
         end
      end
      warn_nxt = low_time(xmin_nxt, xsec_nxt);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Datapath registers: prescaler, digits, latch, pulse, counter, warning.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         min_latch <= 8'h00;
         xmin      <= 8'h00;
         xsec      <= 8'h00;
         time_out  <= 1'b0;
         cycle_cnt <= '0;
         warn      <= 1'b0;
      end else begin
         prescaler <= pre_nxt;
         min_latch <= latch_nxt;
         xmin      <= xmin_nxt;
         xsec      <= xsec_nxt;
         time_out  <= to_nxt;
         cycle_cnt <= cyc_nxt;
         warn      <= warn_nxt;
      end
   end

endmodule

// File: tb/tb_ctd_timer_core.sv
// tb_ctd_timer_core: randomized and directed stimulus for ctd_timer_core,
// checked against an integer-seconds reference model.
module tb_ctd_timer_core;

   localparam int TD = 4;
   localparam int WS = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic       cnt_en = 1'b0;
   logic       auto_mode = 1'b0;
   logic [7:0] min_init = 8'h00;
   logic [7:0] xmin, xsec;
   logic       time_out, done, warn;
   logic [7:0] cycle_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state (remaining time held as plain seconds)
   int m_total, m_pre, m_lmin, m_cyc;
   bit m_done, m_reload, m_to;
   logic [7:0] exp_q[$];
   logic am_r;

   ctd_timer_core #(.TICK_DIV(TD), .WARN_SEC(WS), .CYC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .cnt_en(cnt_en),
      .auto_mode(auto_mode), .min_init(min_init), .xmin(xmin), .xsec(xsec),
      .time_out(time_out), .done(done), .warn(warn), .cycle_cnt(cycle_cnt)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic model_reset();
      m_total = 0; m_pre = 0; m_lmin = 0; m_cyc = 0;
      m_done = 1; m_reload = 0; m_to = 0;
      exp_q.delete();
   endtask

   // advance the model by one clock using the inputs applied for that edge
   task automatic model_clock();
      bit tk, zero;
      int t, u;
      tk = 0; zero = 0;
      m_to = 0;
      if (load) begin
         t = (min_init[7:4] > 9) ? 9 : int'(min_init[7:4]);
         u = (min_init[3:0] > 9) ? 9 : int'(min_init[3:0]);
         m_lmin = t * 10 + u;
         m_total = m_lmin * 60;
         m_pre = 0; m_cyc = 0; m_reload = 0;
         m_done = (m_lmin == 0);
      end else begin
         if (cnt_en && !m_done) begin
            if (m_pre == TD - 1) begin m_pre = 0; tk = 1; end
            else m_pre++;
         end
         if (tk) begin
            if (m_reload) begin
               m_reload = 0;
               m_total = m_lmin * 60;
               zero = (m_total == 0);
            end else if (m_total > 0) begin
               m_total--;
               zero = (m_total == 0);
            end
            if (zero) begin
               m_to = 1;
               m_cyc = (m_cyc + 1) % 256;
               exp_q.push_back(8'(m_cyc));
               if (auto_mode) m_reload = 1;
               else m_done = 1;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [7:0] e;
      check("xmin", xmin, to_bcd(m_total / 60));
      check("xsec", xsec, to_bcd(m_total % 60));
      check("time_out", time_out, m_to);
      check("done", done, m_done);
      check("warn", warn, (m_total != 0 && m_total <= WS));
      check("cycle_cnt", cycle_cnt, m_cyc);
      if (time_out) begin
         if (exp_q.size() == 0) check("to_spurious", time_out, 0);
         else begin
            e = exp_q.pop_front();
            check("to_cyc_sb", cycle_cnt, e);
         end
      end
   endtask

   // driver: apply inputs at negedge, clock once, compare at next negedge
   task automatic step(input logic ld, input logic en, input logic am, input logic [7:0] mi);
      load = ld; cnt_en = en; auto_mode = am; min_init = mi;
      @(posedge clk);
      model_clock();
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_xmin"}, xmin, 8'h00);
      check({tag, "_xsec"}, xsec, 8'h00);
      check({tag, "_to"}, time_out, 0);
      check({tag, "_done"}, done, 1);
      check({tag, "_warn"}, warn, 0);
      check({tag, "_cyc"}, cycle_cnt, 0);
   endtask

   // watchdog
   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      int n, tos;
      bit seen_warn, got_to;
      model_reset();
      am_r = 0;
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;

      // one-shot 02:00 full countdown
      step(1, 1, 0, 8'h02);
      check("ld2_xmin", xmin, 8'h02);
      check("ld2_xsec", xsec, 8'h00);
      repeat (3) step(0, 1, 0, 8'h02);
      check("pre3_xsec", xsec, 8'h00);
      step(0, 1, 0, 8'h02);
      check("t1_xmin", xmin, 8'h01);
      check("t1_xsec", xsec, 8'h59);
      n = 4; seen_warn = 0; got_to = 0;
      while (!got_to && n < 600) begin
         step(0, 1, 0, 8'h02);
         n++;
         if (warn && !seen_warn) begin
            seen_warn = 1;
            check("warn_rise_min", xmin, 8'h00);
            check("warn_rise_sec", xsec, 8'h10);
         end
         if (time_out) got_to = 1;
      end
      check("cd_len", n, 480);
      check("cd_warn_seen", seen_warn, 1);
      check("cd_done", done, 1);
      check("cd_cyc", cycle_cnt, 1);
      check("cd_warn_fall", warn, 0);
      step(0, 1, 0, 8'h02);
      check("cd_to_width", time_out, 0);
      check("cd_done_hold", done, 1);

      // auto-reload 01:00, three periods
      step(1, 1, 1, 8'h01);
      n = 0; tos = 0;
      while (tos == 0 && n < 300) begin
         step(0, 1, 1, 8'h05); n++;
         if (time_out) tos++;
      end
      check("auto_first_len", n, 240);
      check("auto_first_done", done, 0);
      repeat (4) step(0, 1, 1, 8'h05);
      check("auto_rl_xmin", xmin, 8'h01);
      check("auto_rl_xsec", xsec, 8'h00);
      n = 0;
      while (tos < 3 && n < 600) begin
         step(0, 1, 1, 8'h05); n++;
         if (time_out) tos++;
      end
      check("auto_tos", tos, 3);
      check("auto_cyc", cycle_cnt, 3);
      check("auto_done", done, 0);

      // pause preserves prescaler phase
      step(1, 1, 0, 8'h05);
      repeat (2) step(0, 1, 0, 8'h05);
      repeat (7) step(0, 0, 0, 8'h05);
      step(0, 1, 0, 8'h05);
      check("pause_pre_xsec", xsec, 8'h00);
      step(0, 1, 0, 8'h05);
      check("pause_tick_xmin", xmin, 8'h04);
      check("pause_tick_xsec", xsec, 8'h59);

      // load on a tick cycle
      step(1, 1, 0, 8'h03);
      repeat (3) step(0, 1, 0, 8'h03);
      step(1, 1, 0, 8'h07);
      check("ldtick_xmin", xmin, 8'h07);
      check("ldtick_xsec", xsec, 8'h00);
      check("ldtick_to", time_out, 0);
      repeat (3) step(0, 1, 0, 8'h07);
      check("ldtick_hold", xsec, 8'h00);
      step(0, 1, 0, 8'h07);
      check("ldtick_next", xsec, 8'h59);

      // load coinciding with the tick that would reach 00:00
      step(1, 1, 0, 8'h01);
      repeat (239) step(0, 1, 0, 8'h01);
      check("ldzero_pre_xsec", xsec, 8'h01);
      step(1, 1, 0, 8'h02);
      check("ldzero_xmin", xmin, 8'h02);
      check("ldzero_to", time_out, 0);
      check("ldzero_cyc", cycle_cnt, 0);

      // clamping and zero load
      step(1, 1, 0, 8'hA3);
      check("clamp_a3", xmin, 8'h93);
      step(1, 1, 0, 8'h3B);
      check("clamp_3b", xmin, 8'h39);
      step(1, 1, 1, 8'h00);
      check("zero_done", done, 1);
      tos = 0;
      repeat (20) begin
         step(0, 1, 1, 8'h00);
         if (time_out) tos++;
      end
      check("zero_no_to", tos, 0);
      check("zero_xsec", xsec, 8'h00);

      // asynchronous reset mid-run
      step(1, 1, 0, 8'h02);
      repeat (50) step(0, 1, 0, 8'h02);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic ld, en;
         logic [7:0] mi;
         ld = ($urandom_range(0, 299) == 0) || (i == 0);
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 199) == 0) am_r = ~am_r;
         if ($urandom_range(0, 7) == 0) mi = 8'($urandom);
         else mi = {4'd0, 4'($urandom_range(0, 1))};
         step(ld, en, am_r, mi);
      end
      check("sb_left", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
